digest_serializer: RTL and testbench
====================================

Name: digest_serializer

Overview:
- Output-side counterpart to the 136-bit scan input buffer of the SHA3-256 core.
- Detects the rising edge of the core's `complete` flag and captures the 256-bit `digest` into a shift register.
- Streams the digest out in OUT_W-bit words over a valid/ready handshake, most-significant word first.
- Sits between the hashing core and the off-chip/readout logic; single clock domain (`clk`).

Parameters:
- DIGEST_W, 256, width of captured digest.
- OUT_W, 8, width of each output word; must divide DIGEST_W.
- NWORDS, DIGEST_W/OUT_W (derived, localparam), words per digest.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- complete  input  1  level flag from round logic; high while digest is valid.
- digest  input  DIGEST_W  digest from core, sampled only at capture.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  OUT_W  current word = shift register [DIGEST_W-1 -: OUT_W].
- out_valid  output  1  out_data is valid.
- out_last  output  1  high with the final word (index NWORDS-1).
- busy  output  1  high from capture until the last word is accepted.
- overrun  output  1  sticky; a new complete edge arrived while busy.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_last=0, busy=0, overrun=0, out_data=0.
  - Shift register=0, word counter=0, complete_d=0, state=IDLE.
- Edge detect:
  - complete_d is a 1-cycle registered copy of complete.
  - capture_ev = complete & ~complete_d.
  - If complete is already high on the first cycle after reset, that counts as an edge.
- FSM states: IDLE, SEND.
- IDLE:
  - out_valid=0, busy=0.
  - On capture_ev: load shift register with digest, counter=0, go to SEND.
  - Latency: edge sampled at cycle N gives out_valid=1 at cycle N+1.
- SEND:
  - out_valid=1, busy=1; out_data holds the top OUT_W bits.
  - out_last = (counter==NWORDS-1).
  - Handshake fires when out_valid & out_ready.
  - On handshake with counter<NWORDS-1: shift left by OUT_W (zero fill) and increment counter.
  - On handshake with out_last: go to IDLE. out_valid, out_last and busy drop the next cycle.
  - With out_ready held high, words issue back-to-back, one per cycle: NWORDS cycles total.
- Stall: out_ready low holds out_data, out_valid and out_last stable for any number of cycles.
- Capture during SEND:
  - capture_ev is ignored; the digest is not reloaded.
  - overrun is set to 1 and stays set until reset.
- Last-word acceptance coinciding with capture_ev: same rule, the edge is ignored and overrun is set. A new edge is needed after return to IDLE.
- complete staying high after the transfer finishes does not retrigger; a low-then-high transition is required.
- Reset mid-transfer: the next cycle shows all outputs at their reset values; the partial transfer is discarded.
- Counter width: clog2(NWORDS); it must not wrap inside SEND.

Optional Feature:
- Macro: DIGEST_SER_CHECKSUM_EN.
- Defined:
  - After the last digest word, one extra word is sent: the XOR of all NWORDS digest words.
  - The XOR is computed incrementally on each handshake.
  - out_last moves to the checksum word; the transfer is NWORDS+1 words.
  - The checksum register clears on capture and on reset.
- Undefined: no checksum logic; exactly NWORDS words; out_last on word NWORDS-1.

Test Plan:
- Basic stream:
  - Stimulus: reset 2 cycles; digest=256'h00010203…1E1F; complete rises at cycle 5; out_ready=1.
  - Response: out_valid at cycle 6; out_data 8'h00, 8'h01 … 8'h1F on 32 consecutive cycles; out_last only with 8'h1F; busy falls at cycle 38.
- Backpressure:
  - Stimulus: same digest; out_ready toggles 1,0,0,1 repeating.
  - Response: each word held stable while out_ready=0; word order unchanged; out_last with 8'h1F; no words lost or duplicated.
- Overrun:
  - Stimulus: complete pulses low then high again mid-transfer, with a different digest on the input.
  - Response: the original 32 words complete unchanged; overrun=1 and stays 1 after returning to IDLE.
- Level hold:
  - Stimulus: complete held high for 100 cycles.
  - Response: exactly one 32-word transfer, then IDLE with out_valid=0.
- Reset mid-transfer:
  - Stimulus: assert reset after the 10th handshake.
  - Response: the next cycle has out_valid=0, busy=0, overrun=0; a new complete edge restarts from word 0.
- Checksum (DIGEST_SER_CHECKSUM_EN defined):
  - Stimulus: digest all 8'hA5 except the last word = 8'h0F.
  - Response: a 33rd word 8'hAA (31×A5 → A5, XOR 0F) with out_last=1 on it only.

Source files
------------

// File: rtl/digest_serializer_if.sv
// Word stream from the digest serializer to the readout logic.
// The serializer drives data/valid/last through the master modport; the
// consumer returns ready through the slave modport.
interface digest_serializer_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/digest_serializer.sv
// digest_serializer: captures the SHA3-256 digest on the rising edge of the
// core's complete flag and streams it out MSB word first over valid/ready.
// Optional feature macro: DIGEST_SER_CHECKSUM_EN appends one XOR checksum
// word (XOR of all digest words) after the last digest word.
module digest_serializer #(
    parameter int DIGEST_W = 256,
    parameter int OUT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                complete,
    input  logic [DIGEST_W-1:0] digest,
    output logic                busy,
    output logic                overrun,
    digest_serializer_if.master stream
);

    localparam int NWORDS = DIGEST_W / OUT_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_complete_d;
    logic [DIGEST_W-1:0] r_shift;
    logic [CNT_W-1:0]    r_count;
    logic                r_overrun;

    logic                w_capture_ev;
    logic                w_load;
    logic                w_hs;
    logic                w_valid;
    logic                w_last;
    logic [OUT_W-1:0]    w_top;

`ifdef DIGEST_SER_CHECKSUM_EN
    logic [OUT_W-1:0]    r_csum;
    logic                r_csum_phase;
`endif

    // A level that is already high right after reset counts as an edge
    // because reset clears the delayed copy.
    assign w_capture_ev = complete & ~r_complete_d;
    assign w_load       = (r_state == IDLE) && w_capture_ev;
    assign w_valid      = (r_state == SEND);
    assign w_hs         = w_valid & stream.out_ready;
    assign w_top        = r_shift[DIGEST_W-1 -: OUT_W];

`ifdef DIGEST_SER_CHECKSUM_EN
    // The checksum word is the final beat, so last moves onto it.
    assign w_last = w_valid && r_csum_phase;
`else
    assign w_last = w_valid && (r_count == LAST_IDX);
`endif

    assign stream.out_data  = w_top;
    assign stream.out_valid = w_valid;
    assign stream.out_last  = w_last;
    assign busy             = w_valid;
    assign overrun          = r_overrun;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start on a capture edge, return to IDLE once the final word is accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_capture_ev) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_hs && w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Edge detect, overrun flag, digest capture and word shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_complete_d <= 1'b0;
            r_shift      <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
`ifdef DIGEST_SER_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            r_complete_d <= complete;

            // Any edge while a transfer is in flight (including the cycle of
            // the final handshake) is dropped and flagged until reset.
            if (w_capture_ev && (r_state == SEND)) begin
                r_overrun <= 1'b1;
            end

            if (w_load) begin
                r_shift <= digest;
                r_count <= '0;
`ifdef DIGEST_SER_CHECKSUM_EN
                r_csum       <= '0;
                r_csum_phase <= 1'b0;
`endif
            end else if (w_hs) begin
                if (r_count != LAST_IDX) begin
                    r_shift <= {r_shift[DIGEST_W-OUT_W-1:0], {OUT_W{1'b0}}};
                    r_count <= r_count + CNT_W'(1);
`ifdef DIGEST_SER_CHECKSUM_EN
                    r_csum  <= r_csum ^ w_top;
`endif
                end
`ifdef DIGEST_SER_CHECKSUM_EN
                else if (!r_csum_phase) begin
                    // Present the finished checksum in the top word so the
                    // output path stays a plain slice of the shift register.
                    r_shift      <= {r_csum ^ w_top, {(DIGEST_W-OUT_W){1'b0}}};
                    r_csum       <= r_csum ^ w_top;
                    r_csum_phase <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// Testbench for digest_serializer: randomized and directed transfers checked
// by a queue-based scoreboard fed from a word-level reference model.
module tb_digest_serializer;

    localparam int DIGEST_W = 256;
    localparam int OUT_W    = 8;
    localparam int NWORDS   = DIGEST_W / OUT_W;
`ifdef DIGEST_SER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NWT = NWORDS + (CSUM ? 1 : 0);

    logic                clk;
    logic                reset;
    logic                complete;
    logic [DIGEST_W-1:0] digest;
    logic                busy;
    logic                overrun;

    digest_serializer_if #(.OUT_W(OUT_W)) ifc ();

    digest_serializer #(
        .DIGEST_W(DIGEST_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .complete(complete),
        .digest  (digest),
        .busy    (busy),
        .overrun (overrun),
        .stream  (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests_run = 0;
    int unsigned failed    = 0;

    // Expected words: {last, data}
    logic [OUT_W:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: MSB-first word list, plus the XOR word when enabled.
    task automatic push_expected(input logic [DIGEST_W-1:0] d);
        logic [OUT_W-1:0] w;
        logic [OUT_W-1:0] x;
        x = '0;
        for (int i = 0; i < NWORDS; i++) begin
            w = OUT_W'(d >> (DIGEST_W - OUT_W * (i + 1)));
            x = x ^ w;
            exp_q.push_back({(i == NWORDS - 1) && !CSUM, w});
        end
        if (CSUM) exp_q.push_back({1'b1, x});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;
    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(ifc.out_valid), 64'd1);
                check("stall_data", 64'(ifc.out_data), 64'(prev_data));
                check("stall_last", 64'(ifc.out_last), 64'(prev_last));
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(ifc.out_data), 64'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(ifc.out_data), 64'(e[OUT_W-1:0]));
                    check("word_last", 64'(ifc.out_last), 64'(e[OUT_W]));
                end
            end
            prev_stall = ifc.out_valid && !ifc.out_ready;
            prev_data  = ifc.out_data;
            prev_last  = ifc.out_last;
        end
    end

    // Ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    function automatic logic ready_for(input int mode, input int cyc);
        int ph;
        ph = cyc % 4;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (ph == 0) || (ph == 3);
        return logic'($urandom_range(0, 1));
    endfunction

    // One transfer: complete rises, drops after 'hold' cycles, and optionally
    // rises again (with another digest) after 'rise_at' cycles.
    task automatic transfer(input logic [DIGEST_W-1:0] d, input int mode,
                            input int hold, input int rise_at);
        int cyc;
        push_expected(d);
        digest   = d;
        complete = 1'b1;
        cyc      = 0;
        do begin
            ifc.out_ready = ready_for(mode, cyc);
            tick();
            cyc++;
            if (cyc == hold) complete = 1'b0;
            if (rise_at != 0 && cyc == rise_at) begin
                digest   = ~d;
                complete = 1'b1;
            end
        end while (busy && cyc < 3000);
        check("transfer_timeout", 64'(cyc < 3000), 64'd1);
        complete      = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DIGEST_W-1:0] base_d;
        logic [DIGEST_W-1:0] d;
        int n;

        reset         = 1'b1;
        complete      = 1'b0;
        digest        = '0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_last", 64'(ifc.out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_data", 64'(ifc.out_data), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NWORDS; i++) base_d[DIGEST_W-1-OUT_W*i -: OUT_W] = OUT_W'(i);

        // Basic stream: latency and back-to-back word count.
        push_expected(base_d);
        digest        = base_d;
        complete      = 1'b1;
        ifc.out_ready = 1'b1;
        check("lat_pre_valid", 64'(ifc.out_valid), 64'd0);
        tick();
        check("lat_valid", 64'(ifc.out_valid), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        check("first_word", 64'(ifc.out_data), 64'h00);
        n = 1;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check("transfer_cycles", 64'(n), 64'(NWT + 1));
        check("idle_valid", 64'(ifc.out_valid), 64'd0);
        complete      = 1'b0;
        ifc.out_ready = 1'b0;
        tick();

        // Backpressure 1,0,0,1.
        transfer(base_d, 1, 2, 0);

        // Random digests, random ready.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < DIGEST_W / 32; k++) d[32*k +: 32] = $urandom;
            transfer(d, 2, int'($urandom_range(1, 3)), 0);
        end

        // Checksum-pattern digest.
        d = {{(NWORDS-1){8'hA5}}, 8'h0F};
        transfer(d, 2, 1, 0);

        // Level hold: one transfer only.
        push_expected(base_d ^ {NWORDS{8'h3C}});
        digest        = base_d ^ {NWORDS{8'h3C}};
        complete      = 1'b1;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 100; c++) tick();
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_valid", 64'(ifc.out_valid), 64'd0);
        check("hold_queue", 64'(exp_q.size()), 64'd0);
        complete      = 1'b0;
        ifc.out_ready = 1'b0;
        tick();

        // Overrun: new edge mid-transfer with a different digest.
        check("pre_overrun", 64'(overrun), 64'd0);
        for (int k = 0; k < DIGEST_W / 32; k++) d[32*k +: 32] = $urandom;
        transfer(d, 0, 3, 5);
        check("overrun_set", 64'(overrun), 64'd1);
        for (int c = 0; c < 5; c++) tick();
        check("overrun_sticky", 64'(overrun), 64'd1);
        check("overrun_idle", 64'(ifc.out_valid), 64'd0);

        // Reset after the 10th handshake; complete stays high so the first
        // cycle out of reset counts as a fresh edge and restarts at word 0.
        push_expected(base_d);
        digest        = base_d;
        complete      = 1'b1;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 11; c++) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_valid", 64'(ifc.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_data", 64'(ifc.out_data), 64'd0);
        push_expected(base_d);
        reset = 1'b0;
        tick();
        check("restart_word0", 64'(ifc.out_data), 64'h00);
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check("restart_cycles", 64'(n), 64'(NWT));
        complete      = 1'b0;
        ifc.out_ready = 1'b0;
        tick();

        // New edge exactly on the final handshake: ignored, overrun set.
        check("pre_coincide_overrun", 64'(overrun), 64'd0);
        transfer(base_d, 0, 3, NWT);
        check("coincide_overrun", 64'(overrun), 64'd1);
        check("coincide_idle", 64'(busy), 64'd0);

        for (int c = 0; c < 3; c++) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
